// File: rtl/fwd_pkg.sv
// Shared opcode constants and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

    localparam logic [6:0] LOAD_OPCODE   = 7'b0000011;
    localparam logic [6:0] STORE_OPCODE  = 7'b0100011;
    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

    // Stores and branches carry an rd-shaped field that is not a destination.
    function automatic logic writes_rd(input logic [6:0] opcode);
        return !((opcode == STORE_OPCODE) || (opcode == BRANCH_OPCODE));
    endfunction

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_port_select.sv
// Per-read-port priority encoder: youngest matching stage wins; flags a
// load-use stall when that stage holds a load whose data is not yet forwardable.
module fwd_port_select
    import fwd_pkg::*;
#(
    parameter int DEPTH            = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = sel_width(DEPTH)
) (
    input  logic [DEPTH-1:0] i_match,
    input  logic [DEPTH-1:0] i_is_load,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_is_load,
    output logic             o_stall_req
);

    // Scan oldest to youngest so the lowest stage index is the last write.
    always_comb begin
        o_sel       = '0;
        o_is_load   = 1'b0;
        o_stall_req = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (i_match[k-1]) begin
                o_sel       = SEL_W'(k);
                o_is_load   = i_is_load[k-1];
                o_stall_req = i_is_load[k-1] && (k < LOAD_READY_STAGE);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: shift pipeline of in-flight destination tags.
// Optional stall statistics counter enabled by defining FWD_STATS_EN.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_READ_PORTS   = 2,
    parameter int FWD_DEPTH        = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int REG_ADDR_W       = 5
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              issue_valid,
    input  logic [REG_ADDR_W-1:0]                             issue_rd,
    input  logic [6:0]                                        issue_opcode,
    input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0]              rs_addr,
    input  logic                                              pipe_advance,
    input  logic                                              flush,
    output logic [NUM_READ_PORTS*sel_width(FWD_DEPTH)-1:0]    fwd_sel,
    output logic [NUM_READ_PORTS-1:0]                         fwd_is_load,
    output logic                                              load_use_stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                                       stall_count
`endif
);

    localparam int SEL_W = sel_width(FWD_DEPTH);

    // Stage k lives at index k-1.
    logic [FWD_DEPTH-1:0]  r_valid;
    logic [FWD_DEPTH-1:0]  r_is_load;
    logic [REG_ADDR_W-1:0] r_rd [FWD_DEPTH];

    logic                      w_insert;
    logic [NUM_READ_PORTS-1:0] w_stall_req;

    assign w_insert = issue_valid && !load_use_stall && writes_rd(issue_opcode)
                      && (issue_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            r_is_load <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) r_rd[k] <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (pipe_advance) begin
            r_valid[0]   <= w_insert;
            r_rd[0]      <= issue_rd;
            r_is_load[0] <= (issue_opcode == LOAD_OPCODE);
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_valid[k]   <= r_valid[k-1];
                r_rd[k]      <= r_rd[k-1];
                r_is_load[k] <= r_is_load[k-1];
            end
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        logic [REG_ADDR_W-1:0] w_rs;
        logic [FWD_DEPTH-1:0]  w_match;

        assign w_rs = rs_addr[p*REG_ADDR_W +: REG_ADDR_W];

        // x0 is hardwired zero, so it never matches anything.
        always_comb begin
            w_match = '0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                w_match[k] = r_valid[k] && (r_rd[k] == w_rs) && (w_rs != '0);
            end
        end

        fwd_port_select #(
            .DEPTH            (FWD_DEPTH),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .SEL_W            (SEL_W)
        ) u_sel (
            .i_match     (w_match),
            .i_is_load   (r_is_load),
            .o_sel       (fwd_sel[p*SEL_W +: SEL_W]),
            .o_is_load   (fwd_is_load[p]),
            .o_stall_req (w_stall_req[p])
        );
    end

    assign load_use_stall = issue_valid && (|w_stall_req);

`ifdef FWD_STATS_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (load_use_stall && pipe_advance && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and load-use hazard unit for the core pipeline. It sits beside the decode/issue stage and keeps its own registered shift pipeline of destination tags for every in-flight instruction past issue. For each source-register read port it selects either the register file or the youngest matching in-flight stage. It raises a load-use stall when a source matches a load whose data is not yet available.

## Interface
Parameters:
- NUM_READ_PORTS, 2: number of source-register read ports (rs1, rs2, …)
- FWD_DEPTH, 2: number of tracked stages after issue; stage 1 is EX/MEM
- LOAD_READY_STAGE, 2: first stage index (1..FWD_DEPTH) at which load data is forwardable
- REG_ADDR_W, 5: register address width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  an instruction is presented for issue into EX this cycle
- issue_rd  in  REG_ADDR_W  destination register of the presented instruction
- issue_opcode  in  7  opcode of the presented instruction
- rs_addr  in  NUM_READ_PORTS*REG_ADDR_W  source addresses; port p occupies bits [p*REG_ADDR_W +: REG_ADDR_W]
- pipe_advance  in  1  pipeline moves one stage this cycle
- flush  in  1  discard all in-flight tags
- fwd_sel  out  NUM_READ_PORTS*SEL_W  per-port select: 0 = register file, k = stage k
- fwd_is_load  out  NUM_READ_PORTS  per-port flag: the selected stage holds a load, so use the memory-data path
- load_use_stall  out  1  hold issue; the presented instruction is not inserted
- stall_count  out  32  load-use stall cycle counter (present only with FWD_STATS_EN)

## Operation
- SEL_W = $clog2(FWD_DEPTH+1).
- Each stage k in 1..FWD_DEPTH holds valid[k], rd[k] and is_load[k].
- writes_rd(opcode) is false for STORE (0100011) and BRANCH (1100011), and true otherwise.
- Insert condition: issue_valid && !load_use_stall && writes_rd(issue_opcode) && issue_rd != 0.
- On pipe_advance:
  - stage 1 loads the issued tag if the insert condition holds; otherwise it loads a bubble (valid=0).
  - stage k+1 takes stage k.
  - the tag in stage FWD_DEPTH retires and is discarded.
- With pipe_advance low, all tags hold.
- Port match (per port p, stage k): valid[k] && rd[k] == rs_p && rs_p != 0.
- Per port, the lowest matching k wins (youngest instruction).
  - fwd_sel_p = k; fwd_is_load_p = is_load[k].
  - No match: fwd_sel_p = 0, fwd_is_load_p = 0.
- load_use_stall = issue_valid && some port's winning stage k has is_load[k] && k < LOAD_READY_STAGE.
  - A port that only matches on x0 never stalls.
- flush has priority over pipe_advance: all valid[k] <= 0 in the same cycle.
- Reset sets all valid[k] = 0, which makes fwd_sel = 0, fwd_is_load = 0 and load_use_stall = 0. stall_count resets to 0.

## Timing
- fwd_sel, fwd_is_load and load_use_stall are combinational from the current tag registers and the rs_addr / issue_valid inputs, with zero-cycle latency.
- Tag state updates only on the rising edge of clk.
- An instruction issued in cycle N is visible as stage 1 in cycle N+1, provided pipe_advance was high in cycle N.
- A load stalls consumers for exactly LOAD_READY_STAGE-1 advancing cycles. The default is a 1-cycle bubble.
- Same-cycle events:
  - flush with issue_valid: the issued tag is dropped.
  - rst with any input: reset wins.
- A stall while pipe_advance is low holds the stall until the load moves.

## Configuration
- FWD_STATS_EN defined:
  - stall_count increments by 1 on each cycle in which load_use_stall && pipe_advance.
  - It saturates at 32'hFFFF_FFFF.
  - It clears on rst.
- FWD_STATS_EN undefined: the stall_count port and its counter are absent.

## Structure
- Shared package fwd_pkg holds:
  - opcode constants LOAD_OPCODE = 7'b0000011, STORE_OPCODE, BRANCH_OPCODE;
  - the writes_rd function;
  - the SEL_W computation.
- Sub-module fwd_port_select is instanced once per read port. It is the priority encoder from the match vector and is_load vector to sel, is_load and stall_req.

## Test plan
- Defaults; issue ADD x5 with advance; next cycle rs1=x5 -> fwd_sel port0 = 1, fwd_is_load = 0, no stall.
- Issue LW x7, advance; next cycle issue with rs2=x7 -> load_use_stall = 1 for one cycle and the bubble is inserted; after the next advance, port1 sel = 2 with fwd_is_load = 1.
- Same rd x3 in stages 1 and 2, rs1=x3 -> sel = 1 (youngest wins).
- rs1 = 0 with stage 1 rd = 0 attempted (ADD x0) -> no insert, sel = 0, no stall; SW with rd field = 9 -> no insert.
- LW x4 in stage 1, assert flush and pipe_advance together -> next cycle all sel = 0, stall = 0; assert rst mid-stall -> outputs 0, stall_count = 0.
- FWD_STATS_EN: three stall cycles with advance, one with pipe_advance low -> stall_count = 3.
